ris_burst: RTL and testbench



---
 rtl/ris_pkg.sv | 18 +
 rtl/ris_addr_gen.sv | 46 ++++
 rtl/ris_burst.sv | 119 +++++++++++
 tb/tb_ris_burst.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ris_pkg.sv
// Shared types and default geometry for the burst register-interface slave.
package ris_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_LEN_W     = 4;
  localparam int DEF_REG_DEPTH = 256;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DEC,
    XFER,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/ris_addr_gen.sv
// Burst address generator: holds the latched base, length and beat index,
// and presents the register address for the current beat.
module ris_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic              xfer_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] base_o,
  output logic [LEN_W-1:0]  len_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic              last_beat_o
);

  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q <= '0;
      len_q  <= '0;
      beat_q <= '0;
    end else if (load_i) begin
      base_q <= base_i;
      len_q  <= len_i;
      beat_q <= '0;
    end else if (advance_i) begin
      beat_q <= beat_q + LEN_W'(1);
    end
  end

  // The range check upstream guarantees base+beat never wraps.
  assign reg_addr_o  = xfer_i ? base_q + ADDR_W'(beat_q) : base_q;
  assign last_beat_o = (beat_q == len_q);
  assign base_o      = base_q;
  assign len_o       = len_q;

endmodule

// File: rtl/ris_burst.sv
// Burst-capable register interface slave: request FSM, range check and
// register-file strobe decode around the address generator.
module ris_burst
  import ris_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int REG_DEPTH = DEF_REG_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] data_from_RIM,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] rd_from_reg,
  output logic              rdy,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              wr_en,
  output logic              rd_en,
  output logic [DATA_W-1:0] wr_to_reg,
  output logic [DATA_W-1:0] rd_to_RIM,
  output logic              wr_cmd,
  output logic              wr_done,
  output logic              rd_done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(REG_DEPTH);

  state_e            state_q, state_d;
  logic              cmd_q;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len_lat;
  logic              last_beat;
  logic              advance;
  logic [ADDR_W:0]   end_addr;
  logic              range_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cmd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == CMD) cmd_q <= cmd;
    end
  end

  // Extra MSB catches ranges that run past the top of the address space.
  assign end_addr  = {1'b0, base} + (ADDR_W+1)'(len_lat);
  assign range_err = (end_addr >= DEPTH);
  // Reads stream one beat per cycle; writes wait for each data beat.
  assign advance   = (state_q == XFER) && (!cmd_q || data_valid);

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_cmd  = 1'b0;
    wr_done = 1'b0;
    rd_done = 1'b0;
    err     = 1'b0;
    case (state_q)
      IDLE: if (req) state_d = CMD;
      CMD:  state_d = DEC;
      DEC: begin
        rdy     = 1'b1;
        wr_cmd  = cmd_q;
        state_d = range_err ? ERR : XFER;
      end
      XFER: begin
        rdy   = 1'b1;
        wr_en = cmd_q & data_valid;
        rd_en = ~cmd_q;
        if (advance && last_beat) state_d = DONE;
      end
      DONE: begin
        rdy     = 1'b1;
        wr_done = cmd_q;
        rd_done = ~cmd_q;
        state_d = IDLE;
      end
      ERR: begin
        rdy     = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  ris_addr_gen #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == CMD),
    .advance_i  (advance),
    .xfer_i     (state_q == XFER),
    .base_i     (addr),
    .len_i      (len),
    .base_o     (base),
    .len_o      (len_lat),
    .reg_addr_o (reg_addr),
    .last_beat_o(last_beat)
  );

  assign wr_to_reg = data_from_RIM;
  assign rd_to_RIM = rd_from_reg;

endmodule

// File: tb/tb_ris_burst.sv
// Self-checking bench for ris_burst: table of directed bursts plus
// hand-written stall, reset and back-to-back sequences.
module tb_ris_burst;

  logic        clk;
  logic        rst;
  logic        req;
  logic        cmd;
  logic [7:0]  addr;
  logic [3:0]  len;
  logic [15:0] data_from_RIM;
  logic        data_valid;
  logic [15:0] rd_from_reg;
  logic        rdy;
  logic [7:0]  reg_addr;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] wr_to_reg;
  logic [15:0] rd_to_RIM;
  logic        wr_cmd;
  logic        wr_done;
  logic        rd_done;
  logic        err;

  ris_burst #(
    .DATA_W(16), .ADDR_W(8), .LEN_W(4), .REG_DEPTH(256)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .cmd(cmd), .addr(addr), .len(len),
    .data_from_RIM(data_from_RIM), .data_valid(data_valid),
    .rd_from_reg(rd_from_reg), .rdy(rdy), .reg_addr(reg_addr),
    .wr_en(wr_en), .rd_en(rd_en), .wr_to_reg(wr_to_reg),
    .rd_to_RIM(rd_to_RIM), .wr_cmd(wr_cmd), .wr_done(wr_done),
    .rd_done(rd_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy;
    logic       wr_en;
    logic       rd_en;
    logic       wr_cmd;
    logic       wr_done;
    logic       rd_done;
    logic       err;
    logic [7:0] reg_addr;
  } obs_t;

  typedef struct {
    string       name;
    logic        cmd;
    logic [7:0]  addr;
    logic [3:0]  len;
    logic [15:0] rd_data;
    bit          exp_err;
    int          exp_beats;
  } vec_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] last_base = 8'h00;

  task automatic check(input string name, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o = '{rdy, wr_en, rd_en, wr_cmd, wr_done, rd_done, err, reg_addr};
    return o;
  endfunction

  // Expected outputs in cycle c of a burst whose req was sampled at edge 0,
  // with write data always valid.
  function automatic obs_t exp_burst(input int c, input logic wr,
                                     input logic [7:0] base,
                                     input logic [7:0] prev,
                                     input int n, input bit e);
    obs_t o;
    o = '0;
    o.reg_addr = (c <= 1) ? prev : base;
    if (c == 2) begin
      o.rdy = 1'b1;
      o.wr_cmd = wr;
    end else if (e) begin
      if (c == 3) begin
        o.rdy = 1'b1;
        o.err = 1'b1;
      end
    end else if (c >= 3 && c <= 2 + n) begin
      o.rdy = 1'b1;
      o.wr_en = wr;
      o.rd_en = ~wr;
      o.reg_addr = base + 8'(c - 3);
    end else if (c == 3 + n) begin
      o.rdy = 1'b1;
      o.wr_done = wr;
      o.rd_done = ~wr;
    end
    return o;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input string name, input logic c,
                           input logic [7:0] a, input logic [3:0] l,
                           input logic [15:0] rdd, input bit e, input int nb);
    req = 1'b1; cmd = c; addr = a; len = l;
    data_valid = 1'b1; rd_from_reg = rdd;
    for (int cy = 1; cy <= nb + 5; cy++) begin
      next_cycle();
      if (cy == 1) req = 1'b0;
      data_from_RIM = 16'h5A00 + 16'(cy);
      @(negedge clk);
      check(name, cy, 32'(sample()), 32'(exp_burst(cy, c, a, last_base, nb, e)));
      if (cy == 3 && !e)
        check({name, "/data"}, cy, c ? 32'(wr_to_reg) : 32'(rd_to_RIM),
              c ? 32'(16'h5A03) : 32'(rdd));
    end
    last_base = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    obs_t exp_s[10];
    int   beats;

    vecs[0] = '{"rd_single",  1'b0, 8'h10, 4'd0,  16'hBEEF, 1'b0, 1};
    vecs[1] = '{"wr_burst4",  1'b1, 8'h20, 4'd3,  16'h0000, 1'b0, 4};
    vecs[2] = '{"range_err",  1'b0, 8'hFE, 4'd3,  16'h1234, 1'b1, 0};
    vecs[3] = '{"wr_edge_ok", 1'b1, 8'hFC, 4'd3,  16'h0000, 1'b0, 4};
    vecs[4] = '{"rd_top_reg", 1'b0, 8'hFF, 4'd0,  16'hC0DE, 1'b0, 1};
    vecs[5] = '{"rd_len16",   1'b0, 8'hF0, 4'd15, 16'h7777, 1'b0, 16};

    rst = 1'b0; req = 1'b0; cmd = 1'b0; addr = '0; len = '0;
    data_from_RIM = '0; data_valid = 1'b0; rd_from_reg = '0;
    #1;
    check("reset_state", 0, 32'(sample()), 32'(0));
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();

    foreach (vecs[i])
      run_burst(vecs[i].name, vecs[i].cmd, vecs[i].addr, vecs[i].len,
                vecs[i].rd_data, vecs[i].exp_err, vecs[i].exp_beats);

    // Write burst with two stalled cycles after the first beat.
    exp_s[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_base};
    exp_s[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20};
    exp_s[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20};
    exp_s[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h21};
    exp_s[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h21};
    exp_s[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h21};
    exp_s[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22};
    exp_s[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h23};
    exp_s[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20};
    exp_s[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20};
    beats = 0;
    req = 1'b1; cmd = 1'b1; addr = 8'h20; len = 4'd3;
    for (int cy = 1; cy <= 10; cy++) begin
      next_cycle();
      if (cy == 1) req = 1'b0;
      data_valid = !(cy == 4 || cy == 5);
      @(negedge clk);
      check("wr_stall", cy, 32'(sample()), 32'(exp_s[cy-1]));
      if (wr_en) beats++;
    end
    check("wr_stall_beats", 10, 32'(beats), 32'(4));
    last_base = 8'h20;
    data_valid = 1'b1;

    // Reset asserted in cycle 4 of an 8-beat read.
    req = 1'b1; cmd = 1'b0; addr = 8'h40; len = 4'd7; rd_from_reg = 16'hAAAA;
    for (int cy = 1; cy <= 3; cy++) begin
      next_cycle();
      if (cy == 1) req = 1'b0;
      @(negedge clk);
      check("rst_mid_pre", cy, 32'(sample()), 32'(exp_burst(cy, 1'b0, 8'h40, last_base, 8, 1'b0)));
    end
    next_cycle();
    rst = 1'b0;
    #1;
    check("rst_mid_async", 4, 32'(sample()), 32'(0));
    next_cycle();
    check("rst_mid_held", 5, 32'(sample()), 32'(0));
    rst = 1'b1;
    for (int cy = 6; cy <= 8; cy++) begin
      next_cycle();
      @(negedge clk);
      check("rst_mid_idle", cy, 32'(sample()), 32'(0));
    end
    last_base = 8'h00;
    run_burst("post_rst", 1'b0, 8'h33, 4'd2, 16'h4321, 1'b0, 3);

    // Back-to-back 2-beat reads with req held high; addr changes mid-burst.
    beats = 0;
    req = 1'b1; cmd = 1'b0; addr = 8'h30; len = 4'd1; rd_from_reg = 16'h0F0F;
    for (int cy = 1; cy <= 12; cy++) begin
      next_cycle();
      if (cy == 3) addr = 8'h50;
      if (cy == 7) req = 1'b0;
      @(negedge clk);
      if (cy <= 6)
        check("b2b_first", cy, 32'(sample()), 32'(exp_burst(cy, 1'b0, 8'h30, last_base, 2, 1'b0)));
      else
        check("b2b_second", cy, 32'(sample()), 32'(exp_burst(cy - 6, 1'b0, 8'h50, 8'h30, 2, 1'b0)));
      if (rd_en) beats++;
    end
    check("b2b_beats", 12, 32'(beats), 32'(4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
